// File: rtl/spi_cmd_decoder.sv
// SPI mode-0 slave that turns 16-bit command/data frames into a register bus strobe interface.
// Optional aborted-frame counter on o_abort_cnt is built when SPI_DEC_ABORT_CNT_EN is defined.
module spi_cmd_decoder #(
  parameter int N_MOD    = 4,
  parameter int SYNC_LEN = 2
) (
  input  logic                 i_sys_clk,
  input  logic                 i_rst_b,
  input  logic                 i_spi_sck,
  input  logic                 i_spi_mosi,
  input  logic                 i_spi_cs_b,
  output logic                 o_spi_miso,
  output logic [4:0]           o_ioc,
  output logic [7:0]           o_data_out,
  input  logic [8*N_MOD-1:0]   i_mod_data,
  output logic [N_MOD-1:0]     o_cs_vec,
  output logic                 o_fetch_cmd,
  output logic                 o_load_cmd,
  output logic                 o_err
`ifdef SPI_DEC_ABORT_CNT_EN
  ,output logic [7:0]          o_abort_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CMD   = 3'd1,
    S_FETCH = 3'd2,
    S_WAITD = 3'd3,
    S_DATA  = 3'd4,
    S_LOAD  = 3'd5,
    S_DONE  = 3'd6
  } state_e;

  localparam logic [2:0] N_MOD_W = 3'(N_MOD);

  logic [SYNC_LEN-1:0] sck_sync_q;
  logic [SYNC_LEN-1:0] mosi_sync_q;
  logic [SYNC_LEN-1:0] cs_sync_q;
  logic                sck_prev_q;
  logic                cs_prev_q;

  state_e              state_q;
  logic [3:0]          bit_cnt_q;
  logic [7:0]          rx_q;
  logic [7:0]          tx_q;
  logic [1:0]          sel_q;
  logic                sel_ok_q;
  logic                wr_q;
  logic                wait_q;
  logic                miso_q;
  logic [4:0]          ioc_q;
  logic [7:0]          data_out_q;
  logic [N_MOD-1:0]    cs_vec_q;
  logic                fetch_q;
  logic                load_q;
  logic                err_q;

  logic                sck_s;
  logic                mosi_s;
  logic                cs_s;
  logic                sck_rise_s;
  logic                sck_fall_s;
  logic                cs_fall_s;
  logic                cs_rise_s;
  logic                in_frame_s;
  logic                abort_s;
  logic [7:0]          rx_d;
  logic [1:0]          cmd_sel_s;
  logic                cmd_sel_ok_s;
  logic [3:0]          onehot_s;
  logic [31:0]         mod_data_pad_s;
  logic [7:0]          lane_s;

  assign sck_s      = sck_sync_q[SYNC_LEN-1];
  assign mosi_s     = mosi_sync_q[SYNC_LEN-1];
  assign cs_s       = cs_sync_q[SYNC_LEN-1];
  assign sck_rise_s = sck_s & ~sck_prev_q;
  assign sck_fall_s = ~sck_s & sck_prev_q;
  assign cs_fall_s  = ~cs_s & cs_prev_q;
  assign cs_rise_s  = cs_s & ~cs_prev_q;

  assign in_frame_s = (state_q == S_CMD) || (state_q == S_FETCH) ||
                      (state_q == S_WAITD) || (state_q == S_DATA);
  assign abort_s    = cs_rise_s & in_frame_s;

  assign rx_d         = {rx_q[6:0], mosi_s};
  assign cmd_sel_s    = rx_d[6:5];
  assign cmd_sel_ok_s = ({1'b0, cmd_sel_s} < N_MOD_W);
  assign onehot_s     = 4'b0001 << cmd_sel_s;

  // Lanes are padded to four so an out-of-range select can never index past the bus.
  assign mod_data_pad_s = 32'(i_mod_data);
  assign lane_s         = sel_ok_q ? mod_data_pad_s[{sel_q, 3'b000} +: 8] : 8'h00;

  // Synchronise the asynchronous SPI pins and keep one-cycle history for edge detection.
  always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      sck_sync_q  <= {SYNC_LEN{1'b0}};
      mosi_sync_q <= {SYNC_LEN{1'b0}};
      cs_sync_q   <= {SYNC_LEN{1'b1}};
      sck_prev_q  <= 1'b0;
      cs_prev_q   <= 1'b1;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_LEN-2:0], i_spi_sck};
      mosi_sync_q <= {mosi_sync_q[SYNC_LEN-2:0], i_spi_mosi};
      cs_sync_q   <= {cs_sync_q[SYNC_LEN-2:0], i_spi_cs_b};
      sck_prev_q  <= sck_s;
      cs_prev_q   <= cs_s;
    end
  end

  // Frame sequencer with registered bus outputs.
  always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= 4'd0;
      rx_q       <= 8'h00;
      tx_q       <= 8'h00;
      sel_q      <= 2'd0;
      sel_ok_q   <= 1'b0;
      wr_q       <= 1'b0;
      wait_q     <= 1'b0;
      miso_q     <= 1'b0;
      ioc_q      <= 5'd0;
      data_out_q <= 8'h00;
      cs_vec_q   <= {N_MOD{1'b0}};
      fetch_q    <= 1'b0;
      load_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      fetch_q <= 1'b0;
      load_q  <= 1'b0;
      if (abort_s) begin
        state_q  <= S_IDLE;
        cs_vec_q <= {N_MOD{1'b0}};
        miso_q   <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            miso_q <= 1'b0;
            if (cs_fall_s) begin
              state_q   <= S_CMD;
              bit_cnt_q <= 4'd0;
            end else begin
              state_q <= S_IDLE;
            end
          end
          S_CMD: begin
            if (sck_rise_s) begin
              rx_q      <= rx_d;
              bit_cnt_q <= bit_cnt_q + 4'd1;
              if (bit_cnt_q == 4'd7) begin
                ioc_q    <= rx_d[4:0];
                sel_q    <= cmd_sel_s;
                sel_ok_q <= cmd_sel_ok_s;
                wr_q     <= rx_d[7];
                tx_q     <= 8'h00;
                wait_q   <= 1'b0;
                if (cmd_sel_ok_s) begin
                  cs_vec_q <= onehot_s[N_MOD-1:0];
                end else begin
                  cs_vec_q <= {N_MOD{1'b0}};
                  err_q    <= 1'b1;
                end
                state_q <= rx_d[7] ? S_DATA : S_FETCH;
              end else begin
                state_q <= S_CMD;
              end
            end else begin
              state_q <= S_CMD;
            end
          end
          S_FETCH: begin
            fetch_q <= 1'b1;
            wait_q  <= 1'b0;
            state_q <= S_WAITD;
          end
          S_WAITD: begin
            // Second WAITD cycle: the module has had one cycle to present its read data.
            if (wait_q) begin
              tx_q    <= lane_s;
              state_q <= S_DATA;
            end else begin
              wait_q  <= 1'b1;
              state_q <= S_WAITD;
            end
          end
          S_DATA: begin
            if (sck_rise_s) begin
              rx_q      <= rx_d;
              bit_cnt_q <= bit_cnt_q + 4'd1;
              if (bit_cnt_q == 4'd15) begin
                if (wr_q && sel_ok_q) begin
                  data_out_q <= rx_d;
                  state_q    <= S_LOAD;
                end else begin
                  state_q <= S_DONE;
                end
              end else begin
                state_q <= S_DATA;
              end
            end else if (sck_fall_s) begin
              miso_q  <= tx_q[7];
              tx_q    <= {tx_q[6:0], 1'b0};
              state_q <= S_DATA;
            end else begin
              state_q <= S_DATA;
            end
          end
          S_LOAD: begin
            load_q <= 1'b1;
            miso_q <= 1'b0;
            if (cs_rise_s) begin
              cs_vec_q <= {N_MOD{1'b0}};
              state_q  <= S_IDLE;
            end else begin
              state_q <= S_DONE;
            end
          end
          S_DONE: begin
            miso_q <= 1'b0;
            if (cs_rise_s) begin
              cs_vec_q <= {N_MOD{1'b0}};
              state_q  <= S_IDLE;
            end else begin
              state_q <= S_DONE;
            end
          end
          default: begin
            state_q  <= S_IDLE;
            cs_vec_q <= {N_MOD{1'b0}};
            miso_q   <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef SPI_DEC_ABORT_CNT_EN
  logic [7:0] abort_cnt_q;

  // Saturating count of frames cut short by chip select.
  always_ff @(posedge i_sys_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      abort_cnt_q <= 8'h00;
    end else if (abort_s && (abort_cnt_q != 8'hFF)) begin
      abort_cnt_q <= abort_cnt_q + 8'h01;
    end else begin
      abort_cnt_q <= abort_cnt_q;
    end
  end

  assign o_abort_cnt = abort_cnt_q;
`endif

  assign o_spi_miso  = miso_q;
  assign o_ioc       = ioc_q;
  assign o_data_out  = data_out_q;
  assign o_cs_vec    = cs_vec_q;
  assign o_fetch_cmd = fetch_q;
  assign o_load_cmd  = load_q;
  assign o_err       = err_q;

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Scoreboard bench for spi_cmd_decoder: a 4-module instance and a 2-module instance
// share the SPI clock/data lines and have their own chip selects.
module tb_spi_cmd_decoder;

  typedef struct packed {
    logic [4:0] ioc;
    logic [7:0] data;
    logic [3:0] cs;
  } wr_exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sck = 1'b0;
  logic        mosi = 1'b0;
  logic        cs_drv = 1'b1;
  logic        tgt = 1'b0;
  logic        cs_b1, cs_b2;

  logic        miso1, fetch1, load1, err1;
  logic [4:0]  ioc1;
  logic [7:0]  dout1;
  logic [3:0]  cs1;
  logic [31:0] mod_data1;
  logic        miso2, fetch2, load2, err2;
  logic [4:0]  ioc2;
  logic [7:0]  dout2;
  logic [1:0]  cs2;
  logic [15:0] mod_data2 = 16'hBBAA;
`ifdef SPI_DEC_ABORT_CNT_EN
  logic [7:0]  abort_cnt1, abort_cnt2;
`endif

  logic [7:0]  lane_q   [4] = '{8'h3C, 8'hC3, 8'h96, 8'h69};
  logic [7:0]  lane_src [4] = '{8'h01, 8'hEE, 8'h5A, 8'hDD};
  logic [7:0]  last_wr  [2] = '{8'h00, 8'h00};

  wr_exp_t     wr_q1[$];
  wr_exp_t     wr_q2[$];
  logic [7:0]  rd_q[$];
  wr_exp_t     e1, e2;

  int n_cmp = 0;
  int n_err = 0;
  int fetch_cnt1 = 0;
  int load_cnt1 = 0;
  int load_cnt2 = 0;
  logic both_seen = 1'b0;

  assign cs_b1 = tgt ? 1'b1 : cs_drv;
  assign cs_b2 = tgt ? cs_drv : 1'b1;
  assign mod_data1 = {lane_q[3], lane_q[2], lane_q[1], lane_q[0]};

  always #5 clk = ~clk;

  spi_cmd_decoder #(.N_MOD(4), .SYNC_LEN(2)) u_dut (
    .i_sys_clk(clk), .i_rst_b(rst_n), .i_spi_sck(sck), .i_spi_mosi(mosi),
    .i_spi_cs_b(cs_b1), .o_spi_miso(miso1), .o_ioc(ioc1), .o_data_out(dout1),
    .i_mod_data(mod_data1), .o_cs_vec(cs1), .o_fetch_cmd(fetch1),
    .o_load_cmd(load1), .o_err(err1)
`ifdef SPI_DEC_ABORT_CNT_EN
    , .o_abort_cnt(abort_cnt1)
`endif
  );

  spi_cmd_decoder #(.N_MOD(2), .SYNC_LEN(2)) u_dut2 (
    .i_sys_clk(clk), .i_rst_b(rst_n), .i_spi_sck(sck), .i_spi_mosi(mosi),
    .i_spi_cs_b(cs_b2), .o_spi_miso(miso2), .o_ioc(ioc2), .o_data_out(dout2),
    .i_mod_data(mod_data2), .o_cs_vec(cs2), .o_fetch_cmd(fetch2),
    .o_load_cmd(load2), .o_err(err2)
`ifdef SPI_DEC_ABORT_CNT_EN
    , .o_abort_cnt(abort_cnt2)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Register modules of the 4-lane instance: present read data one cycle after a selected fetch.
  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (fetch1 && cs1[k]) lane_q[k] <= lane_src[k];
    end
  end

  // Strobe monitor: each load pulse pops and checks the expected bus write.
  always @(negedge clk) begin
    if (fetch1) fetch_cnt1++;
    if ((fetch1 && load1) || (fetch2 && load2)) both_seen = 1'b1;
    if (load1) begin
      load_cnt1++;
      chk("ld_pending1", {31'd0, wr_q1.size() != 0}, 32'd1);
      if (wr_q1.size() != 0) begin
        e1 = wr_q1.pop_front();
        chk("ld_ioc1", {27'd0, ioc1}, {27'd0, e1.ioc});
        chk("ld_data1", {24'd0, dout1}, {24'd0, e1.data});
        chk("ld_cs1", {28'd0, cs1}, {28'd0, e1.cs});
      end
    end
    if (load2) begin
      load_cnt2++;
      chk("ld_pending2", {31'd0, wr_q2.size() != 0}, 32'd1);
      if (wr_q2.size() != 0) begin
        e2 = wr_q2.pop_front();
        chk("ld_ioc2", {27'd0, ioc2}, {27'd0, e2.ioc});
        chk("ld_data2", {24'd0, dout2}, {24'd0, e2.data});
        chk("ld_cs2", {28'd0, cs2}, {28'd0, e2.cs[1:0]});
      end
    end
  end

  task automatic spi_xfer(input logic [15:0] tx, input int nbits, output logic [15:0] rx);
    rx = 16'h0000;
    cs_drv = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      mosi = (i < 16) ? tx[15-i] : 1'b1;
      repeat (8) @(negedge clk);
      sck = 1'b1;
      if (i < 16) rx[15-i] = tgt ? miso2 : miso1;
      repeat (8) @(negedge clk);
      sck = 1'b0;
    end
    repeat (8) @(negedge clk);
  endtask

  task automatic spi_end();
    cs_drv = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic do_frame(input logic [7:0] cmd, input logic [7:0] dat, input int nbits,
                          input logic [3:0] exp_cs, input logic [7:0] exp_miso,
                          input logic exp_ld);
    logic [15:0] rx;
    wr_exp_t w;
    w.ioc = cmd[4:0];
    w.data = dat;
    w.cs = exp_cs;
    if (exp_ld) begin
      if (tgt) wr_q2.push_back(w);
      else wr_q1.push_back(w);
      last_wr[tgt] = dat;
    end
    rd_q.push_back(exp_miso);
    fetch_cnt1 = 0;
    load_cnt1 = 0;
    load_cnt2 = 0;
    spi_xfer({cmd, dat}, nbits, rx);
    chk("cs_vec", {28'd0, tgt ? {2'b00, cs2} : cs1}, {28'd0, exp_cs});
    chk("ioc", {27'd0, tgt ? ioc2 : ioc1}, {27'd0, cmd[4:0]});
    chk("load_cnt", tgt ? load_cnt2 : load_cnt1, {31'd0, exp_ld});
    if (!tgt) chk("fetch_cnt", fetch_cnt1, {31'd0, ~cmd[7]});
    chk("miso_cmd", {24'd0, rx[15:8]}, 32'd0);
    chk("miso_data", {24'd0, rx[7:0]}, {24'd0, rd_q.pop_front()});
    chk("data_out", {24'd0, tgt ? dout2 : dout1}, {24'd0, last_wr[tgt]});
    spi_end();
    chk("cs_clear", {28'd0, tgt ? {2'b00, cs2} : cs1}, 32'd0);
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rx;
    repeat (3) @(negedge clk);
    chk("rst_outs", {11'd0, miso1, ioc1, dout1, cs1, fetch1, load1, err1}, 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    tgt = 1'b0;
    do_frame(8'h84, 8'hA5, 16, 4'b0001, 8'h00, 1'b1);
    do_frame(8'h00, 8'h00, 16, 4'b0001, 8'h01, 1'b0);
    do_frame(8'h41, 8'h00, 16, 4'b0100, 8'h5A, 1'b0);
    do_frame(8'hA3, 8'h3C, 16, 4'b0010, 8'h00, 1'b1);
    do_frame(8'hFF, 8'h81, 18, 4'b1000, 8'h00, 1'b1);
    do_frame(8'h63, 8'h00, 16, 4'b1000, 8'hDD, 1'b0);
    chk("err1_clean", {31'd0, err1}, 32'd0);

    tgt = 1'b1;
    do_frame(8'hE0, 8'h55, 16, 4'b0000, 8'h00, 1'b0);
    chk("err2_set", {31'd0, err2}, 32'd1);
    do_frame(8'hC0, 8'h00, 16, 4'b0000, 8'h00, 1'b0);
    do_frame(8'hA1, 8'h77, 16, 4'b0010, 8'h00, 1'b1);
    chk("err2_sticky", {31'd0, err2}, 32'd1);
    chk("err1_isolated", {31'd0, err1}, 32'd0);

    tgt = 1'b0;
    load_cnt1 = 0;
    spi_xfer(16'h85F0, 12, rx);
    chk("abort_cs_mid", {28'd0, cs1}, 32'd1);
    spi_end();
    chk("abort_noload", load_cnt1, 32'd0);
    chk("abort_cs_clr", {28'd0, cs1}, 32'd0);
    chk("abort_hold", {24'd0, dout1}, {24'd0, last_wr[0]});
`ifdef SPI_DEC_ABORT_CNT_EN
    chk("abort_cnt_1", {24'd0, abort_cnt1}, 32'd1);
    for (int i = 0; i < 256; i++) begin
      cs_drv = 1'b0;
      repeat (4) @(negedge clk);
      cs_drv = 1'b1;
      repeat (6) @(negedge clk);
    end
    chk("abort_cnt_sat", {24'd0, abort_cnt1}, 32'hFF);
`endif
    do_frame(8'h82, 8'h5C, 16, 4'b0001, 8'h00, 1'b1);

    load_cnt1 = 0;
    spi_xfer(16'h8A5C, 10, rx);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_outs", {11'd0, miso1, ioc1, dout1, cs1, fetch1, load1, err1}, 32'd0);
`ifdef SPI_DEC_ABORT_CNT_EN
    chk("rst_mid_abort", {24'd0, abort_cnt1}, 32'd0);
`endif
    sck = 1'b0;
    cs_drv = 1'b1;
    last_wr[0] = 8'h00;
    last_wr[1] = 8'h00;
    repeat (5) @(negedge clk);
    chk("rst_mid_noload", load_cnt1, 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    do_frame(8'h87, 8'h3E, 16, 4'b0001, 8'h00, 1'b1);

    chk("strobe_excl", {31'd0, both_seen}, 32'd0);
    chk("wr_q1_left", wr_q1.size(), 32'd0);
    chk("wr_q2_left", wr_q2.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
